// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding, frame geometry and the parity helper.
// Optional build macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 1085;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity over one data byte: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with natural-wrap pointers and an occupancy count.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [7:0]             din_i,
  input  logic                   pop_i,
  output logic [7:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy tracking; simultaneous push+pop leaves count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are
// serialized LSB first. Back-to-back frames have no idle gap.
// Optional build macro: UART_TX_PARITY_EN (even parity bit after the data).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_phy,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  tx_state_e              state_q;
  logic [BW-1:0]          baud_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   tx_phy_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic [7:0]             head_s;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .din_i   (tx_data),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (fifo_count)
  );

  // Ready and busy decode only registered state, so tx_valid never reaches them.
  assign tx_ready = !full_s;
  assign push_s   = tx_valid && tx_ready;
  assign tx_busy  = (state_q != IDLE) || (fifo_count != '0);
  assign tx_phy   = tx_phy_q;

  // Pop the FIFO head when idle, or at the very end of a stop bit for gapless frames.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = !empty_s;
      STOP:    pop_s = (baud_q == '0) && !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Serializer FSM and baud counter; the line flop follows the state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      tx_phy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_phy_q <= 1'b1;
          if (pop_s) begin
            shift_q   <= head_s;
            baud_q    <= BAUD_RELOAD;
            bit_idx_q <= 3'd0;
            state_q   <= START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= even_parity(head_s);
`endif
          end
        end
        START: begin
          tx_phy_q <= 1'b0;
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        DATA: begin
          tx_phy_q <= shift_q[0];
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_phy_q <= parity_q;
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        STOP: begin
          tx_phy_q <= 1'b1;
          if (baud_q == '0) begin
            if (pop_s) begin
              shift_q   <= head_s;
              baud_q    <= BAUD_RELOAD;
              bit_idx_q <= 3'd0;
              state_q   <= START;
`ifdef UART_TX_PARITY_EN
              parity_q  <= even_parity(head_s);
`endif
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          tx_phy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes are queued; a line monitor decodes frames mid-bit and compares.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = CPB * FRAME_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_phy;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_phy     (tx_phy),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         last_wait;
  int         last_cnt;
  logic       rule_en = 1'b0;
  logic       saw_full = 1'b0;
  logic       peak_en = 1'b0;
  int         peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one byte at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (!tx_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    last_wait = guard;
    last_cnt = int'(fifo_count);
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
      tx_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((tx_busy || exp_q.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle", name, tx_busy, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_gaps(input int base, input int n, input string name);
    chk({name, "_frames"}, starts_q.size(), base + n);
    if (starts_q.size() == base + n) begin
      for (int i = 0; i < n - 1; i++) begin
        chk({name, "_gap"}, starts_q[base+i+1] - starts_q[base+i], FRAME_CYC);
      end
    end
  endtask

  // Line monitor: decodes each frame at mid-bit and scores it against the queue.
  initial begin : monitor
    logic                  prev;
    logic                  aborted;
    logic [FRAME_BITS-1:0] bits;
    logic [7:0]            want;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !tx_phy) begin
        starts_q.push_back(cyc);
        aborted = 1'b0;
        bits = '0;
        for (int o = 0; o < FRAME_CYC; o++) begin
          if (o > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (o % CPB == CPB / 2) bits[o/CPB] = tx_phy;
        end
        if (!aborted) begin
          chk("start_bit", bits[0], 1'b0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %02h expected no frame", bits[8:1]);
          end else begin
            want = exp_q.pop_front();
            chk("data_byte", bits[8:1], want);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", bits[9], ^want);
`endif
          end
          chk("stop_bit", bits[FRAME_BITS-1], 1'b1);
          prev = tx_phy;
        end else begin
          prev = 1'b1;
        end
      end else begin
        prev = tx_phy;
      end
    end
  end

  // Handshake rule and occupancy tracking while enabled.
  initial begin : rules
    forever begin
      @(negedge clk);
      if (rule_en) begin
        chk("ready_rule", tx_ready, (fifo_count != 3'(DEPTH)));
        if (fifo_count == 3'(DEPTH)) saw_full = 1'b1;
      end
      if (peak_en && int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  initial begin : stim
    int base;
    logic [7:0] hold_bytes [6];
    hold_bytes[0] = 8'h01; hold_bytes[1] = 8'h82; hold_bytes[2] = 8'hC3;
    hold_bytes[3] = 8'h24; hold_bytes[4] = 8'hE5; hold_bytes[5] = 8'h66;

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_phy", tx_phy, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_phy", tx_phy, 1'b1);
      chk("idle_busy", tx_busy, 1'b0);
      chk("idle_ready", tx_ready, 1'b1);
      chk("idle_count", fifo_count, 3'd0);
    end

    // Single byte: latency and busy window.
    send(8'hA5);
    chk("lat_count", fifo_count, 3'd1);
    chk("lat_busy", tx_busy, 1'b1);
    chk("lat_phy_n", tx_phy, 1'b1);
    @(negedge clk);
    chk("lat_phy_n1", tx_phy, 1'b1);
    chk("lat_popped", fifo_count, 3'd0);
    @(negedge clk);
    chk("lat_fall", tx_phy, 1'b0);
    repeat (FRAME_CYC - 2) @(negedge clk);
    chk("busy_in_stop", tx_busy, 1'b1);
    @(negedge clk);
    chk("busy_after_frame", tx_busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("a5_consumed", exp_q.size(), 0);

    // Three back-to-back bytes.
    base = starts_q.size();
    peak = 0;
    peak_en = 1'b1;
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    wait_idle("b2b");
    peak_en = 1'b0;
    chk("b2b_peak", peak, 2);
    check_gaps(base, 3, "b2b");

    // Hold valid with six bytes: fill the FIFO and wait on backpressure.
    base = starts_q.size();
    rule_en = 1'b1;
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) send(hold_bytes[i]);
    chk("full_waited", (last_wait > 0), 1'b1);
    chk("accept_after_pop_cnt", last_cnt, 3);
    chk("refilled", fifo_count, 3'd4);
    wait_idle("hold");
    rule_en = 1'b0;
    chk("saw_full", saw_full, 1'b1);
    check_gaps(base, 6, "hold");

    // Reset during data bit 3 of 0x3C with two bytes queued.
    send(8'h3C);
    send(8'h11);
    send(8'h22);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_phy", tx_phy, 1'b1);
    chk("midrst_count", fifo_count, 3'd0);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_ready", tx_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    base = starts_q.size();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("postrst_phy", tx_phy, 1'b1);
    end
    chk("postrst_frames", starts_q.size(), base);

`ifdef UART_TX_PARITY_EN
    base = starts_q.size();
    send(8'h07);
    send(8'h03);
    wait_idle("parity");
    check_gaps(base, 2, "parity");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serializes them onto the line as 8N1, LSB first.
- Sits beside the receive path inside the UART top and drives the board uart_tx pin.
- Its tx_busy output is intended for an LED.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per bit (125 MHz / 115200 baud, truncated); must be >= 2.
- FIFO_DEPTH, 16, byte entries in the buffer; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept a byte this cycle
- tx_phy  output  1  serial line, idle high
- tx_busy  output  1  frame in progress or FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered

Behaviour:
- Reset and outputs:
  - One clock; rst is synchronous and active-high.
  - Reset values: tx_phy=1, tx_ready=1, tx_busy=0, fifo_count=0. FIFO pointers cleared; state is IDLE.
  - tx_phy is driven straight from a flop (glitch-free).
- Handshake:
  - A byte is accepted on a rising edge when tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH), decoded from registered state only; there is no combinational path from tx_valid.
  - While full, tx_ready=0. A pop in the same cycle does not enable a push; the push is accepted the next cycle.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap naturally.
  - fifo_count increments on push-only and decrements on pop-only. It is unchanged on simultaneous push+pop, which is legal whenever not full.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_phy=1. If FIFO is non-empty, pop the head into the shift register, load baud counter = CLKS_PER_BIT-1, bit index = 0, go to START.
  - START: tx_phy=0 for CLKS_PER_BIT cycles.
  - DATA: tx_phy = shift[0] for each bit period. Shift right at the end of each period. After bit index 7, go to STOP.
  - STOP: tx_phy=1 for CLKS_PER_BIT cycles. At the end of the period:
    - if FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames;
    - otherwise go to IDLE.
- Timing:
  - Baud counter counts down and reloads at 0. A frame lasts exactly 10*CLKS_PER_BIT cycles.
  - Latency: byte accepted at edge N into an empty, idle block → fifo_count=1 after N → pop at edge N+1 → tx_phy=0 from edge N+2.
- tx_busy = (state != IDLE) || (fifo_count != 0). It is registered-equivalent, with no combinational input path.
- Reset mid-frame: on the next edge tx_phy=1, the FSM returns to IDLE and the FIFO is flushed. The truncated frame is abandoned and never resumed.
- Push while empty and mid-frame: the byte is buffered and sent back-to-back after the current STOP.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - adds a PARITY state between DATA and STOP;
  - tx_phy = XOR of the 8 data bits (even parity) for one bit period;
  - frame = 11*CLKS_PER_BIT cycles.
- Undefined: 8N1 exactly as above; no PARITY state or logic is synthesized.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - DEFAULT_CLKS_PER_BIT=1085.
- One natural sub-module: byte_fifo, containing the storage, pointers and count, with push/pop/full/empty/count ports.
- The FSM and baud counter live in uart_tx_buffered.

Test Plan:
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset, then idle 50 cycles → tx_phy=1, tx_busy=0, tx_ready=1, fifo_count=0 throughout.
- Push 0xA5 once → tx_phy falls 2 cycles after acceptance; sampled mid-bit it reads 0,1,0,1,0,0,1,0,1,1; frame is 40 cycles; tx_busy deasserts on return to IDLE.
- Push 0x00,0xFF,0x55 back-to-back → three frames with no idle cycles between STOP and START; fifo_count peaks at 2.
- Hold tx_valid with 6 bytes → tx_ready drops when fifo_count=4; the 5th byte is accepted only the cycle after the first pop; all 6 bytes appear on the line in order.
- Assert rst during DATA bit 3 of 0x3C with 2 bytes queued → tx_phy=1 the next cycle, fifo_count=0, no further frames.
- With UART_TX_PARITY_EN defined, send 0x07 → parity bit=1 and frame is 44 cycles; send 0x03 → parity bit=0.
